// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/allowin on both sides,
// plus stage stall (masks the head) and flush (discards everything).
module pipe_stage_fifo #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2,
    parameter int AF_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    output logic                       in_allowin,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_allowin,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       almost_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;

    // Handshake terms depend only on registered state and stall, so no in->out comb path.
    assign in_allowin  = (count != CW'(DEPTH));
    assign out_valid   = (count != '0) & ~stall;
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(DEPTH - AF_LEVEL));
    assign out_data    = mem[rd_ptr];

    assign push = in_valid & in_allowin;
    assign pop  = out_valid & out_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately unreset; out_data is only meaningful while out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!resetn) count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn) !(pop && count == '0));
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scenario bench for pipe_stage_fifo (DEPTH=3); a negedge scoreboard tracks every push/pop.
module tb_pipe_stage_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 3;
    localparam int AF = 1;

    logic          clk = 1'b0;
    logic          resetn, flush, stall, in_valid, out_allowin;
    logic [DW-1:0] in_data;
    logic          in_allowin, out_valid, empty, almost_full;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_q [$];

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_data(in_data),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_data(out_data),
        .count(count), .empty(empty), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    // Scoreboard: inputs are stable at negedge and are what the next posedge acts on.
    always @(negedge clk) begin
        if (!resetn) begin
            model_q.delete();
        end else begin
            automatic int  sz = model_q.size();
            automatic bit  m_pop  = out_allowin && !stall && (sz != 0);
            automatic bit  m_push = in_valid && (sz != DEPTH);
            checks++;
            if (count !== 2'(sz) || out_valid !== ((sz != 0) && !stall) || in_allowin !== (sz != DEPTH)
                || empty !== (sz == 0) || almost_full !== (sz >= DEPTH - AF)) begin
                errors++;
                $display("FAIL status: count=%0d ov=%b ia=%b empty=%b af=%b, expected count=%0d stall=%b",
                         count, out_valid, in_allowin, empty, almost_full, sz, stall);
            end
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_pop) begin
                    checks++;
                    if (out_data !== model_q[0]) begin
                        errors++;
                        $display("FAIL pop_data: got %h expected %h", out_data, model_q[0]);
                    end
                    void'(model_q.pop_front());
                end
                if (m_push) model_q.push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; out_allowin = 0; stall = 0; flush = 0; in_data = '0;
    endtask

    task automatic drain();
        int n = 0;
        out_allowin = 1; in_valid = 0; stall = 0;
        while (!empty && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL drain_timeout: count=%0d expected 0", count);
        end
        out_allowin = 0;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_data = base + DW'(i);
            step();
        end
        in_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        push_n(2, 8'h10);
        #2 resetn = 0;
        #1;
        checks++;
        if (out_valid !== 0 || empty !== 1 || count !== 0 || in_allowin !== 1 || almost_full !== 0) begin
            errors++;
            $display("FAIL reset: ov=%b empty=%b count=%0d ia=%b af=%b, expected 0 1 0 1 0",
                     out_valid, empty, count, in_allowin, almost_full);
        end
        step();
        resetn = 1;
        step();
    endtask

    task automatic test_fill_drain();
        idle();
        push_n(3, 8'hA1);
        checks++;
        if (count !== 3 || in_allowin !== 0 || almost_full !== 1) begin
            errors++;
            $display("FAIL fill: count=%0d ia=%b af=%b, expected 3 0 1", count, in_allowin, almost_full);
        end
        // Offer data while full: must be refused (scoreboard enforces it).
        in_valid = 1; in_data = 8'hEE;
        step();
        in_valid = 0;
        out_allowin = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1 || out_data !== 8'hA1 + DW'(i)) begin
                errors++;
                $display("FAIL drain_seq: ov=%b data=%h expected 1 %h", out_valid, out_data, 8'hA1 + DW'(i));
            end
            step();
        end
        checks++;
        if (empty !== 1) begin
            errors++;
            $display("FAIL drain_empty: empty=%b expected 1", empty);
        end
        idle();
    endtask

    task automatic test_stream();
        idle();
        in_valid = 1; out_allowin = 1;
        for (int i = 0; i < 10; i++) begin
            in_data = DW'(i);
            step();
            checks++;
            if (count !== 1 || out_data !== DW'(i)) begin
                errors++;
                $display("FAIL stream: count=%0d data=%h expected 1 %h", count, out_data, DW'(i));
            end
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [13:0] ops = 14'b10_100110_100110; // LSB first: 1=push 0=pop
        logic [DW-1:0] d = 8'h30;
        idle();
        for (int i = 0; i < 14; i++) begin
            in_valid = ops[i];
            out_allowin = ~ops[i];
            in_data = d;
            if (ops[i]) d++;
            step();
        end
        drain();
        checks++;
        if (model_q.size() != 0 || d !== 8'h37) begin
            errors++;
            $display("FAIL wrap: leftover=%0d pushes=%0d expected 0 7", model_q.size(), d - 8'h30);
        end
    endtask

    task automatic test_stall();
        idle();
        push_n(2, 8'h51);
        stall = 1; out_allowin = 1;
        in_valid = 1; in_data = 8'h53;
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 0;
            checks++;
            if (out_valid !== 0 || out_data !== 8'h51 || count !== 3) begin
                errors++;
                $display("FAIL stall: ov=%b data=%h count=%0d expected 0 51 3", out_valid, out_data, count);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        idle();
        push_n(2, 8'h61);
        flush = 1; stall = 1; in_valid = 1; in_data = 8'hFF;
        step();
        flush = 0; stall = 0; in_valid = 0; out_allowin = 1;
        checks++;
        if (count !== 0 || empty !== 1 || out_valid !== 0) begin
            errors++;
            $display("FAIL flush: count=%0d empty=%b ov=%b expected 0 1 0", count, empty, out_valid);
        end
        for (int i = 0; i < 3; i++) step();
        // Buffer still usable after a flush.
        push_n(1, 8'h71);
        drain();
    endtask

    initial begin
        resetn = 0;
        idle();
        step(); step();
        resetn = 1;
        step();
        test_reset();
        test_fill_drain();
        test_stream();
        test_wrap();
        test_stall();
        test_flush();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
